risc_proc_mc: RTL and testbench

Parametrised multi-cycle successor to the simple RISC processor datapath. Accepts one instruction per cycle over a valid/ready handshake, executes ADD/SUB/MUL/logic ops in a single cycle and DIV/MOD on an iterative restoring divider, and returns a registered result with status flags. Sits between the instruction issue stage and the result writeback/monitor logic.

---
 rtl/risc_proc_mc_if.sv | 30 +++
 rtl/risc_proc_mc.sv | 195 +++++++++++++++++++
 tb/tb_risc_proc_mc.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/risc_proc_mc_if.sv
// Instruction/result bus for risc_proc_mc. Valid/ready: an instruction transfers on the
// rising edge where instr_valid && instr_ready; result_valid is a one-cycle completion pulse.
interface risc_proc_mc_if #(
    parameter int OPND_W = 6,
    parameter int DATA_W = 16
);
    localparam int IW = 4 + 2*OPND_W;

    logic              instr_valid;
    logic              instr_ready;
    logic [IW-1:0]     instr;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic [DATA_W-1:0] regA;
    logic [DATA_W-1:0] regB;
    logic              carry;
    logic              zero;
    logic              err;
    logic              dbg_state;

    modport master (
        output instr_valid, instr,
        input  instr_ready, result, result_valid, regA, regB, carry, zero, err, dbg_state
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, result, result_valid, regA, regB, carry, zero, err, dbg_state
    );
endinterface

// File: rtl/risc_proc_mc.sv
// Multi-cycle RISC datapath: single-cycle ALU ops plus an iterative restoring divider.
// Divider built only when RISC_PROC_DIV_EN is defined; otherwise DIV/MOD are illegal ops.
module risc_proc_mc #(
    parameter int OPND_W = 6,
    parameter int DATA_W = 16
) (
    input logic            clk,
    input logic            reset_n,
    risc_proc_mc_if.slave  bus
);
    localparam int IW = 4 + 2*OPND_W;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_DIV = 4'h4;
    localparam logic [3:0] OP_MOD = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;

    logic [DATA_W-1:0] result_q, result_d, rega_q, rega_d, regb_q, regb_d;
    logic              carry_q, carry_d, zero_q, zero_d, err_q, err_d, valid_q, valid_d;

    logic [3:0]          op;
    logic [OPND_W-1:0]   a, b;
    logic [OPND_W:0]     sum;
    logic [2*OPND_W-1:0] prod;
    logic [DATA_W-1:0]   res_n;
    logic                car_n, err_n, done_n;
    logic                accept;

`ifdef RISC_PROC_DIV_EN
    typedef enum logic {IDLE = 1'b0, DIVIDE = 1'b1} state_t;
    localparam int CW = $clog2(OPND_W + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OPND_W-1:0] rem_q, rem_d, dvd_q, dvd_d;
    logic              mod_q, mod_d;
    logic              start_n;
    logic [OPND_W:0]   trial, diff;
    logic              qbit;
    logic [OPND_W-1:0] rem_nx, quo_nx;

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.dbg_state   = state_q;
`else
    assign bus.instr_ready = 1'b1;
    assign bus.dbg_state   = 1'b0;
`endif

    assign accept = bus.instr_valid && bus.instr_ready;

    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        rega_d   = rega_q;
        regb_d   = regb_q;

        op   = bus.instr[IW-1 -: 4];
        a    = bus.instr[2*OPND_W-1 -: OPND_W];
        b    = bus.instr[OPND_W-1:0];
        sum  = {1'b0, a} + {1'b0, b};
        prod = (2*OPND_W)'(a) * (2*OPND_W)'(b);

        res_n  = '1;
        car_n  = 1'b0;
        err_n  = 1'b0;
        done_n = 1'b1;
`ifdef RISC_PROC_DIV_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        mod_d   = mod_q;
        start_n = 1'b0;

        // Restoring step: trial >= divisor exactly when the subtraction does not borrow.
        trial  = {rem_q, dvd_q[OPND_W-1]};
        diff   = trial - {1'b0, regb_q[OPND_W-1:0]};
        qbit   = ~diff[OPND_W];
        rem_nx = qbit ? diff[OPND_W-1:0] : trial[OPND_W-1:0];
        quo_nx = {dvd_q[OPND_W-2:0], qbit};
`endif

        case (op)
            OP_NOP: done_n = 1'b0;
            OP_ADD: begin res_n = DATA_W'(sum); car_n = sum[OPND_W]; end
            OP_SUB: begin res_n = DATA_W'(a) - DATA_W'(b); car_n = (a < b); end
            OP_MUL: res_n = DATA_W'(prod);
            OP_AND: res_n = DATA_W'(a & b);
            OP_OR:  res_n = DATA_W'(a | b);
            OP_XOR: res_n = DATA_W'(a ^ b);
`ifdef RISC_PROC_DIV_EN
            OP_DIV, OP_MOD: begin
                if (b == '0) begin
                    err_n = 1'b1;
                end else begin
                    done_n  = 1'b0;
                    start_n = 1'b1;
                end
            end
`endif
            default: err_n = 1'b1;
        endcase

        if (accept) begin
            rega_d = DATA_W'(a);
            regb_d = DATA_W'(b);
            if (done_n) begin
                result_d = res_n;
                carry_d  = car_n;
                err_d    = err_n;
                zero_d   = (res_n == '0);
                valid_d  = 1'b1;
            end
`ifdef RISC_PROC_DIV_EN
            if (start_n) begin
                state_d = DIVIDE;
                cnt_d   = '0;
                rem_d   = '0;
                dvd_d   = a;
                mod_d   = (op == OP_MOD);
            end
`endif
        end

`ifdef RISC_PROC_DIV_EN
        if (state_q == DIVIDE) begin
            rem_d = rem_nx;
            dvd_d = quo_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(OPND_W - 1)) begin
                state_d  = IDLE;
                result_d = DATA_W'(mod_q ? rem_nx : quo_nx);
                carry_d  = 1'b0;
                err_d    = 1'b0;
                zero_d   = ((mod_q ? rem_nx : quo_nx) == '0);
                valid_d  = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            rega_q   <= '0;
            regb_q   <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            rega_q   <= rega_d;
            regb_q   <= regb_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

`ifdef RISC_PROC_DIV_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            mod_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            mod_q   <= mod_d;
        end
    end
`endif

    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.regA         = rega_q;
    assign bus.regB         = regb_q;
    assign bus.carry        = carry_q;
    assign bus.zero         = zero_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_risc_proc_mc.sv
// Directed bench for risc_proc_mc: driver issues instructions and queues expected results,
// a negedge monitor pops and compares on every result_valid.
module tb_risc_proc_mc;
    localparam int OPND_W = 6;
    localparam int DATA_W = 16;
    localparam int EW     = DATA_W + 3;
`ifdef RISC_PROC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3,
                           OP_DIV = 4'h4, OP_MOD = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
                           OP_XOR = 4'h8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    risc_proc_mc_if #(.OPND_W(OPND_W), .DATA_W(DATA_W)) bus ();

    risc_proc_mc #(.OPND_W(OPND_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (reset_n && bus.result_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result_valid: result %0h, nothing expected", bus.result);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", 32'(bus.result), 32'(mon_e[EW-1:3]));
                check("carry",  32'(bus.carry),  32'(mon_e[2]));
                check("zero",   32'(bus.zero),   32'(mon_e[1]));
                check("err",    32'(bus.err),    32'(mon_e[0]));
            end
        end
    end

    // Driver: holds the instruction until accepted, returns 1 time unit after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                         input bit has_res, input logic [15:0] r,
                         input logic c, input logic z, input logic e);
        int w = 0;
        if (has_res) exp_q.push_back({r, c, z, e});
        bus.instr_valid = 1'b1;
        bus.instr       = {op, a, b};
        while (!bus.instr_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!bus.instr_ready) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic count_busy(input int exp_cycles);
        int busy = 0;
        int w = 0;
        while (w < 30) begin
            @(negedge clk);
            w++;
            if (bus.instr_ready) break;
            busy++;
        end
        check("ready_low_cycles", 32'(busy), 32'(exp_cycles));
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_result", 32'(bus.result), 32'h0);
        check("rst_regA",   32'(bus.regA),   32'h0);
        check("rst_regB",   32'(bus.regB),   32'h0);
        check("rst_carry",  32'(bus.carry),  32'h0);
        check("rst_zero",   32'(bus.zero),   32'h0);
        check("rst_err",    32'(bus.err),    32'h0);
        check("rst_valid",  32'(bus.result_valid), 32'h0);
        check("rst_ready",  32'(bus.instr_ready),  32'h1);
        @(negedge clk);

        // Back-to-back adds: result_valid on consecutive cycles
        issue(OP_ADD, 6'd5, 6'd3, 1, 16'd8, 0, 0, 0);
        check("b2b_valid_1", 32'(bus.result_valid), 32'h1);
        issue(OP_ADD, 6'd63, 6'd1, 1, 16'd64, 1, 0, 0);
        check("b2b_valid_2", 32'(bus.result_valid), 32'h1);
        check("regA_load", 32'(bus.regA), 32'd63);
        check("regB_load", 32'(bus.regB), 32'd1);

        issue(OP_SUB, 6'd10, 6'd7, 1, 16'd3, 0, 0, 0);
        issue(OP_SUB, 6'd3, 6'd5, 1, 16'hFFFE, 1, 0, 0);
        issue(OP_XOR, 6'd5, 6'd5, 1, 16'd0, 0, 1, 0);
        issue(OP_AND, 6'd12, 6'd10, 1, 16'd8, 0, 0, 0);
        issue(OP_OR, 6'd12, 6'd3, 1, 16'd15, 0, 0, 0);
        issue(OP_MUL, 6'd63, 6'd63, 1, 16'h0F81, 0, 0, 0);

        // NOP loads operands but leaves result/flags untouched
        issue(OP_NOP, 6'd7, 6'd9, 0, 16'd0, 0, 0, 0);
        check("nop_regA", 32'(bus.regA), 32'd7);
        check("nop_regB", 32'(bus.regB), 32'd9);
        @(negedge clk);
        check("nop_result_hold", 32'(bus.result), 32'h0F81);

        issue(4'hF, 6'd1, 6'd2, 1, 16'hFFFF, 0, 0, 1);
        issue(4'h9, 6'd1, 6'd2, 1, 16'hFFFF, 0, 0, 1);
        issue(OP_DIV, 6'd5, 6'd0, 1, 16'hFFFF, 0, 0, 1);
        check("div0_valid_next", 32'(bus.result_valid), 32'h1);

        issue(OP_DIV, 6'd9, 6'd3, 1, DIV_EN ? 16'd3 : 16'hFFFF, 0, 0, !DIV_EN);
        count_busy(DIV_EN ? OPND_W : 0);
        issue(OP_MOD, 6'd9, 6'd4, 1, DIV_EN ? 16'd1 : 16'hFFFF, 0, 0, !DIV_EN);
        count_busy(DIV_EN ? OPND_W : 0);
        issue(OP_DIV, 6'd1, 6'd63, 1, DIV_EN ? 16'd0 : 16'hFFFF, 0, DIV_EN, !DIV_EN);
        issue(OP_MOD, 6'd60, 6'd7, 1, DIV_EN ? 16'd4 : 16'hFFFF, 0, 0, !DIV_EN);
        issue(OP_DIV, 6'd63, 6'd1, 1, DIV_EN ? 16'd63 : 16'hFFFF, 0, 0, !DIV_EN);
        issue(OP_ADD, 6'd0, 6'd0, 1, 16'd0, 0, 1, 0);
        drain();

        // Reset in the middle of a divide
        issue(OP_DIV, 6'd60, 6'd7, !DIV_EN, 16'hFFFF, 0, 0, 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_result", 32'(bus.result), 32'h0);
        check("midrst_regA",   32'(bus.regA),   32'h0);
        check("midrst_err",    32'(bus.err),    32'h0);
        check("midrst_valid",  32'(bus.result_valid), 32'h0);
        check("midrst_ready",  32'(bus.instr_ready),  32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("postrst_result", 32'(bus.result), 32'h0);
        check("postrst_ready",  32'(bus.instr_ready), 32'h1);

        issue(OP_MUL, 6'd4, 6'd2, 1, 16'd8, 0, 0, 0);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
